// File: rtl/data_bus_arbiter_if.sv
// ============================================================================
// Module   : data_bus_arbiter_if
// Purpose  : Requester, memory and IO signal bundle for data_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_bus_arbiter_if;
  // Requester 0 (CPU) and requester 1 (UART loader)
  logic        req0;
  logic        req1;
  logic        write0;
  logic        write1;
  logic        is_io0;
  logic        is_io1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [31:0] rdata;
  logic        bus_error;

  // Data memory port
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  // IO port
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_read;
  logic        io_write;
  logic [15:0] io_rdata;
  logic        io_ready;

  modport master (
    output req0, req1, write0, write1, is_io0, is_io1,
    output addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, done0, done1, rdata, bus_error,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata,
    input  io_addr, io_wdata, io_read, io_write,
    output io_rdata, io_ready
  );

  modport slave (
    input  req0, req1, write0, write1, is_io0, is_io1,
    input  addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, done0, done1, rdata, bus_error,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata,
    output io_addr, io_wdata, io_read, io_write,
    input  io_rdata, io_ready
  );
endinterface

`default_nettype wire

// File: rtl/data_bus_arbiter.sv
// ============================================================================
// Module   : data_bus_arbiter
// Purpose  : Round-robin arbiter sharing the data memory / IO path between
//            the CPU and the UART loader, with IO ready timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_bus_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int IO_TIMEOUT  = 15
) (
  input logic               clk,
  input logic               rst_n,
  data_bus_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_IO   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] MEM_LAST = 8'(MEM_LATENCY - 1);
  localparam logic [7:0] IO_LAST  = 8'(IO_TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next;

  logic        r_sel;
  logic        r_prio;
  logic        r_write;
  logic        r_io;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_any;
  logic        w_pick1;
  logic        w_mem_last;
  logic        w_io_last;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_done0;
  logic        w_done1;
  logic [31:0] w_rdata;
  logic        w_bus_error;
  logic [31:0] w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic        w_mem_read;
  logic        w_mem_write;
  logic [31:0] w_io_addr;
  logic [31:0] w_io_wdata;
  logic        w_io_read;
  logic        w_io_write;

  // r_prio names the requester that wins when both ask at once
  assign w_any      = bus.req0 | bus.req1;
  assign w_pick1    = bus.req1 & (~bus.req0 | r_prio);
  assign w_mem_last = (r_cnt == MEM_LAST);
  assign w_io_last  = (r_cnt == IO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next = (w_pick1 ? bus.is_io1 : bus.is_io0) ? S_IO : S_MEM;
        end
      end
      S_MEM: begin
        if (w_mem_last) begin
          w_next = S_DONE;
        end
      end
      S_IO: begin
        if (bus.io_ready || w_io_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel   <= 1'b0;
      r_prio  <= 1'b0;
      r_write <= 1'b0;
      r_io    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_cnt   <= 8'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel   <= w_pick1;
            r_write <= w_pick1 ? bus.write1 : bus.write0;
            r_io    <= w_pick1 ? bus.is_io1 : bus.is_io0;
            r_addr  <= w_pick1 ? bus.addr1  : bus.addr0;
            r_wdata <= w_pick1 ? bus.wdata1 : bus.wdata0;
            r_cnt   <= 8'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
          end
        end
        S_MEM: begin
          if (w_mem_last) begin
            if (!r_write) begin
              r_rdata <= bus.mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_IO: begin
          // Ready on the timeout cycle still counts as a successful access
          if (bus.io_ready) begin
            if (!r_write) begin
              r_rdata <= {16'd0, bus.io_rdata};
            end
          end else if (w_io_last) begin
            r_err   <= 1'b1;
            r_rdata <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_prio <= ~r_sel;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_done0     = 1'b0;
    w_done1     = 1'b0;
    w_rdata     = 32'd0;
    w_bus_error = 1'b0;
    w_mem_addr  = 32'd0;
    w_mem_wdata = 32'd0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_io_addr   = 32'd0;
    w_io_wdata  = 32'd0;
    w_io_read   = 1'b0;
    w_io_write  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Grants are combinational, so keep them quiet while reset is held
        w_gnt0 = rst_n & w_any & ~w_pick1;
        w_gnt1 = rst_n & w_any & w_pick1;
      end
      S_MEM: begin
        w_mem_addr  = r_addr;
        w_mem_wdata = r_wdata;
        w_mem_read  = ~r_write;
        w_mem_write = r_write;
      end
      S_IO: begin
        w_io_addr  = r_addr;
        w_io_wdata = r_wdata;
        w_io_read  = ~r_write;
        w_io_write = r_write;
      end
      S_DONE: begin
        w_done0     = ~r_sel;
        w_done1     = r_sel;
        w_rdata     = r_rdata;
        w_bus_error = r_err;
      end
      default: ;
    endcase
  end

  assign bus.gnt0      = w_gnt0;
  assign bus.gnt1      = w_gnt1;
  assign bus.done0     = w_done0;
  assign bus.done1     = w_done1;
  assign bus.rdata     = w_rdata;
  assign bus.bus_error = w_bus_error;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.mem_read  = w_mem_read;
  assign bus.mem_write = w_mem_write;
  assign bus.io_addr   = w_io_addr;
  assign bus.io_wdata  = w_io_wdata;
  assign bus.io_read   = w_io_read;
  assign bus.io_write  = w_io_write;

endmodule

`default_nettype wire

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Shares the single data-memory / memory-mapped-IO access path between two requesters: requester 0 is the CPU load/store path, requester 1 is the UART program/data loader.
- Sits between the requesters and the data-memory block RAM plus IO bus, upstream of the CPU's memory/IO data steering.
- Sequences each access through a small FSM: fixed memory read latency, IO ready handshake with timeout.
- Returns read data, zero-extending 16-bit IO data to 32 bits.

Parameters:
- MEM_LATENCY, 1, cycles from memory strobe to valid iMemRData (1..7).
- IO_TIMEOUT, 15, max cycles waiting for iIoReady before aborting (1..255).

Ports:
- iClock  input  1  system clock, rising edge.
- iResetN  input  1  asynchronous active-low reset.
- iReq0 / iReq1  input  1  access request from requester 0 / 1.
- iWrite0 / iWrite1  input  1  1 = store, 0 = load.
- iIsIo0 / iIsIo1  input  1  1 = IO space, 0 = data memory.
- iAddr0 / iAddr1  input  32  byte address.
- iWData0 / iWData1  input  32  store data.
- oGnt0 / oGnt1  output  1  one-cycle pulse: request accepted and latched.
- oDone0 / oDone1  output  1  one-cycle pulse: access complete.
- oRData  output  32  load data, valid only while oDone0 or oDone1 is high.
- oBusError  output  1  high with oDone* when an IO access timed out.
- oMemAddr  output  32  memory address.
- oMemWData  output  32  memory store data.
- oMemRead / oMemWrite  output  1  memory strobes.
- iMemRData  input  32  memory read data.
- oIoAddr  output  32  IO address.
- oIoWData  output  32  IO store data.
- oIoRead / oIoWrite  output  1  IO strobes.
- iIoRData  input  16  IO read data.
- iIoReady  input  1  IO slave done.

Behaviour:
- Reset (async, iResetN=0): FSM to IDLE; every output 0; round-robin pointer to requester 0; latched request cleared. Any access in flight is abandoned with no oDone.
- FSM states: IDLE, MEM_ACCESS, IO_ACCESS, DONE.
- IDLE:
  - With any iReq high, select a requester: if only one requests, it wins; if both request, the one not served last wins (round robin, first pick after reset = 0).
  - Winner's oGnt pulses in the same cycle; its write, io, address and wdata are registered.
  - Next state is IO_ACCESS if io else MEM_ACCESS.
- MEM_ACCESS:
  - oMemAddr and oMemWData driven from latched values; oMemRead or oMemWrite held high.
  - Counter runs MEM_LATENCY cycles. On the last cycle: for loads, capture iMemRData; go to DONE.
  - Stores also take MEM_LATENCY cycles.
- IO_ACCESS:
  - oIoAddr, oIoWData and oIoRead/oIoWrite held.
  - If iIoReady is sampled high, capture {16'b0, iIoRData} on loads and go to DONE.
  - After IO_TIMEOUT cycles without ready, set the error flag, capture data 0, and go to DONE.
  - iIoReady in the same cycle as the timeout counts as success.
- DONE:
  - All strobes low. oDone for the served requester, oRData and oBusError valid for exactly one cycle.
  - Round-robin pointer updated; return to IDLE.
- Latency: memory access is grant + MEM_LATENCY + 1 cycles to oDone. Minimum spacing between grants is MEM_LATENCY+2 cycles.
- Requester rules:
  - Hold iReq and operands stable until oGnt. Operands are don't-care after grant.
  - iReq still high in the cycle after oDone is a new request.
  - Deasserting iReq before grant withdraws the request with no side effects.
- No grant is issued outside IDLE; requests arriving while busy wait.
- oGnt0 and oGnt1 are never high together; the same holds for oDone0/oDone1.
- The memory and IO strobes are mutually exclusive, and at most one strobe is high at any time.
- Address and data outputs are 0 whenever their strobes are low.

Test Plan:
- Reset mid-access: assert iResetN=0 during MEM_ACCESS → all outputs 0 immediately; after release, IDLE; no oDone for the abandoned access.
- Single memory load, MEM_LATENCY=1: iReq0, iAddr0=0x10, iMemRData=0xDEADBEEF → oGnt0 at cycle 0; oMemRead high cycle 1; oDone0 with oRData=0xDEADBEEF at cycle 2.
- Memory store: iReq1, iWrite1=1, iAddr1=0x20, iWData1=0x12345678 → oMemWrite=1, oMemAddr=0x20, oMemWData=0x12345678 for 1 cycle, then oDone1; oRData=0.
- Contention: iReq0 and iReq1 held high continuously → grants alternate 0,1,0,1, spaced 3 cycles apart (MEM_LATENCY=1).
- IO load: iIsIo0=1, iAddr0=0xFFFFFC70, iIoReady rises 3 cycles after strobe with iIoRData=0xA5A5 → oRData=0x0000A5A5, oBusError=0.
- IO timeout: iIoReady never asserts, IO_TIMEOUT=15 → strobe low after 15 cycles; oDone0=1, oBusError=1, oRData=0; next request is served normally.
